link_transceiver: RTL and testbench
===================================

# link_transceiver

Board-to-board message link for two-player mode: converts the menu/game FSM's `send_connect`, `send_start` and `send_game_finish` flags into framed serial bytes on `tx`. Decodes frames arriving on `rx` into single-cycle `receive_connect`, `receive_start` and `receive_game_finish` pulses for the same FSM. Sits between the stage FSM and the inter-board GPIO pins; a cross-over cable connects one board's `tx` to the other board's `rx`.

## Interface
- `CLKS_PER_BIT`, default 100: clock cycles per serial bit, minimum 4 and even; 100 gives 1 Mbaud at 100 MHz.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `send_connect` in 1: level; a rising edge queues a CONNECT message.
- `send_start` in 1: level or pulse; a rising edge queues a START message.
- `send_game_finish` in 1: level or pulse; a rising edge queues a FINISH message.
- `rx` in 1: asynchronous serial input; idles high.
- `tx` out 1: serial output; idles high.
- `receive_connect` out 1: one-cycle pulse when a valid CONNECT frame is received.
- `receive_start` out 1: one-cycle pulse when a valid START frame is received.
- `receive_game_finish` out 1: one-cycle pulse when a valid FINISH frame is received.
- `tx_busy` out 1: high while a frame is being shifted out.
- `rx_error` out 1: one-cycle pulse on a bad frame.

## Operation
- Message codes: CONNECT = 8'hA1, START = 8'hA2, FINISH = 8'hA3. Any other byte is invalid.
- Frame format, in order: start bit 0, 8 data bits LSB first, optional parity bit (see Configuration), stop bit 1.
- Edge detection: each send input is registered every cycle. A rising edge sets that input's pending bit.
  - A pending bit that is already set stays set; repeated edges merge into one message.
  - A pending bit clears when its frame is loaded into the shifter.
- TX FSM states: IDLE → SHIFT → IDLE.
  - In IDLE with any pending bit set, load the highest-priority message: CONNECT > START > FINISH. Go to SHIFT and raise `tx_busy`.
  - In SHIFT, each bit is held for exactly CLKS_PER_BIT cycles.
  - After the stop bit completes, return to IDLE.
  - IDLE → SHIFT for the next pending message happens on the next cycle, so there is no idle gap beyond one cycle.
- RX path: `rx` passes through a 2-flop synchronizer.
- RX FSM states: IDLE → START → DATA → (PARITY) → STOP → IDLE, plus BREAK.
  - IDLE: a synchronized low moves to START.
  - START: after CLKS_PER_BIT/2 cycles, re-sample. If high (glitch), return to IDLE with no error. If low, go to DATA.
  - DATA: sample 8 bits, one every CLKS_PER_BIT cycles, each at mid-bit.
  - STOP: sample the stop bit at mid-bit. If 1, parity is OK and the code is valid, pulse the matching `receive_*` output. Otherwise pulse `rx_error`.
  - A stop bit of 0 pulses `rx_error` and moves to BREAK.
  - BREAK: wait until synchronized `rx` is high, then return to IDLE.
- TX and RX are fully independent; simultaneous transmit and receive is required (full duplex).

## Timing
- Reset values: `tx` = 1, `tx_busy` = 0, all `receive_*` = 0, `rx_error` = 0. Pending bits, edge registers, both FSMs and all counters are cleared.
  - The edge registers reset to 0, so a send input already high at reset release produces an edge one cycle later.
- Reset mid-frame: `tx` returns high on the next cycle. The partial frame is abandoned and is not retransmitted.
- Send input rises at edge k: pending bit set at k. `tx` drops to 0 at k+1 and `tx_busy` = 1 from k+1.
- Frame duration: 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity. `tx_busy` falls one cycle after the stop bit ends, unless another message is pending.
- RX latency: the `receive_*` pulse occurs 2 cycles (synchronizer) after the mid-stop-bit sample point. It is high for exactly 1 cycle.
- Simultaneous rising edges on several send inputs: all become pending and are sent back-to-back in priority order.
- The bit counter saturates nowhere; it wraps only inside a frame. The CLKS_PER_BIT counter width is $clog2(CLKS_PER_BIT).

## Configuration
- `LINK_PARITY_EN` defined: TX inserts an even-parity bit after the data bits. RX checks it, and a mismatch pulses `rx_error` with no `receive_*` pulse. Frame is 11 bits.
- `LINK_PARITY_EN` undefined: no parity bit. Frame is 10 bits. The PARITY state is not generated.

## Test plan
- Loopback with `tx` tied to `rx`, CLKS_PER_BIT = 16, one-cycle `send_start` pulse → `tx` waveform 0,0,1,0,0,0,1,0,1,1 (8'hA2 LSB first), each bit 16 cycles; `receive_start` pulses once, all other `receive_*` stay 0.
- `send_connect` held high for 1000 cycles → exactly one CONNECT frame is sent.
- `send_connect`, `send_start` and `send_game_finish` rise in the same cycle → frames A1, A2, A3 are sent back-to-back; `tx_busy` stays high continuously for 30·16 cycles plus at most 2 cycles of turnaround.
- Inject byte 8'h55 on `rx` → `rx_error` pulses once and no `receive_*` pulse occurs. Inject A3 with a stop bit of 0 → `rx_error` pulses, the FSM holds in BREAK until `rx` goes high, and a following valid A1 then yields `receive_connect`.
- A 5-cycle low glitch on an idle `rx` → no error and no pulse. Assert `reset` at bit 4 of a TX frame → `tx` = 1 and `tx_busy` = 0 on the next cycle, and no frame follows.
- With `LINK_PARITY_EN` defined, inject A2 with flipped parity → `rx_error` pulses and `receive_start` stays 0. The same byte with correct parity → `receive_start` pulses.

Source files
------------

// File: rtl/link_transceiver.sv
`default_nettype none
// ============================================================================
// Module      : link_transceiver
// Description : Framed serial message link (CONNECT/START/FINISH) between two
//               boards, full duplex. Optional even parity via LINK_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module link_transceiver #(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic send_connect,
    input  logic send_start,
    input  logic send_game_finish,
    input  logic rx,
    output logic tx,
    output logic receive_connect,
    output logic receive_start,
    output logic receive_game_finish,
    output logic tx_busy,
    output logic rx_error
);

    localparam int C_CW = $clog2(CLKS_PER_BIT);
    localparam logic [C_CW-1:0] C_BIT_LAST  = C_CW'(CLKS_PER_BIT - 1);
    localparam logic [C_CW-1:0] C_HALF_LAST = C_CW'(CLKS_PER_BIT / 2 - 1);
`ifdef LINK_PARITY_EN
    localparam int C_FRAME_BITS = 11;
`else
    localparam int C_FRAME_BITS = 10;
`endif
    localparam int          C_PAYLOAD   = C_FRAME_BITS - 1;
    localparam logic [3:0]  C_TX_LAST   = 4'(C_FRAME_BITS - 1);
    localparam logic [7:0]  C_CONNECT   = 8'hA1;
    localparam logic [7:0]  C_START     = 8'hA2;
    localparam logic [7:0]  C_FINISH    = 8'hA3;

    typedef enum logic [0:0] {TX_IDLE, TX_SHIFT} tx_state_t;
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef LINK_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // ---------------- transmit path ----------------
    tx_state_t              tx_state_q, tx_state_d;
    logic [2:0]             send_prev_q, send_prev_d;
    logic [2:0]             pending_q, pending_d;
    logic [C_CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [3:0]             tx_bit_q, tx_bit_d;
    logic [C_PAYLOAD-1:0]   tx_shift_q, tx_shift_d;
    logic                   tx_q, tx_d;
    logic                   tx_busy_q, tx_busy_d;
    logic [2:0]             w_send, w_rise, w_load_mask;
    logic [7:0]             w_tx_byte;

    assign w_send = {send_game_finish, send_start, send_connect};
    assign w_rise = w_send & ~send_prev_q;

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_d        = tx_q;
        tx_busy_d   = tx_busy_q;
        w_load_mask = 3'b000;
        w_tx_byte   = C_CONNECT;
        send_prev_d = w_send;

        case (tx_state_q)
            TX_IDLE: begin
                tx_d      = 1'b1;
                tx_busy_d = 1'b0;
                if (|pending_q) begin
                    if (pending_q[0]) begin
                        w_load_mask = 3'b001;
                        w_tx_byte   = C_CONNECT;
                    end else if (pending_q[1]) begin
                        w_load_mask = 3'b010;
                        w_tx_byte   = C_START;
                    end else begin
                        w_load_mask = 3'b100;
                        w_tx_byte   = C_FINISH;
                    end
                    tx_state_d = TX_SHIFT;
                    tx_d       = 1'b0;
                    tx_busy_d  = 1'b1;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
`ifdef LINK_PARITY_EN
                    tx_shift_d = {1'b1, ^w_tx_byte, w_tx_byte};
`else
                    tx_shift_d = {1'b1, w_tx_byte};
`endif
                end
            end
            TX_SHIFT: begin
                if (tx_cnt_q == C_BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == C_TX_LAST) begin
                        // Busy stays up across the one-cycle turnaround when more is queued
                        tx_state_d = TX_IDLE;
                        tx_d       = 1'b1;
                        tx_busy_d  = |(pending_q | w_rise);
                    end else begin
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b1, tx_shift_q[C_PAYLOAD-1:1]};
                        tx_bit_d   = tx_bit_q + 4'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        pending_d = (pending_q & ~w_load_mask) | w_rise;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q  <= TX_IDLE;
            send_prev_q <= '0;
            pending_q   <= '0;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '1;
            tx_q        <= 1'b1;
            tx_busy_q   <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            send_prev_q <= send_prev_d;
            pending_q   <= pending_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_q        <= tx_d;
            tx_busy_q   <= tx_busy_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = tx_busy_q;

    // ---------------- receive path ----------------
    rx_state_t          rx_state_q, rx_state_d;
    logic               rx_meta_q, rx_sync_q;
    logic [C_CW-1:0]    rx_cnt_q, rx_cnt_d;
    logic [2:0]         rx_bit_q, rx_bit_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic [2:0]         recv_q, recv_d;
    logic               rx_err_q, rx_err_d;
    logic               w_par_ok;
`ifdef LINK_PARITY_EN
    logic               rx_par_q, rx_par_d;
    assign w_par_ok = (rx_par_q == ^rx_data_q);
`else
    assign w_par_ok = 1'b1;
`endif

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_data_d  = rx_data_q;
        recv_d     = 3'b000;
        rx_err_d   = 1'b0;
`ifdef LINK_PARITY_EN
        rx_par_d   = rx_par_q;
`endif
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == C_HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == C_BIT_LAST) begin
                    rx_cnt_d  = '0;
                    rx_data_d = {rx_sync_q, rx_data_q[7:1]};
                    rx_bit_d  = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
`ifdef LINK_PARITY_EN
                        rx_state_d = RX_PARITY;
`else
                        rx_state_d = RX_STOP;
`endif
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
`ifdef LINK_PARITY_EN
            RX_PARITY: begin
                if (rx_cnt_q == C_BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_par_d   = rx_sync_q;
                    rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
`endif
            RX_STOP: begin
                if (rx_cnt_q == C_BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    if (!rx_sync_q) begin
                        rx_err_d   = 1'b1;
                        rx_state_d = RX_BREAK;
                    end else if (w_par_ok && rx_data_q == C_CONNECT) begin
                        recv_d = 3'b001;
                    end else if (w_par_ok && rx_data_q == C_START) begin
                        recv_d = 3'b010;
                    end else if (w_par_ok && rx_data_q == C_FINISH) begin
                        recv_d = 3'b100;
                    end else begin
                        rx_err_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_BREAK: begin
                if (rx_sync_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_data_q  <= '0;
            recv_q     <= '0;
            rx_err_q   <= 1'b0;
`ifdef LINK_PARITY_EN
            rx_par_q   <= 1'b0;
`endif
        end else begin
            rx_state_q <= rx_state_d;
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_data_q  <= rx_data_d;
            recv_q     <= recv_d;
            rx_err_q   <= rx_err_d;
`ifdef LINK_PARITY_EN
            rx_par_q   <= rx_par_d;
`endif
        end
    end

    assign receive_connect     = recv_q[0];
    assign receive_start       = recv_q[1];
    assign receive_game_finish = recv_q[2];
    assign rx_error            = rx_err_q;

endmodule
`default_nettype wire

// File: tb/tb_link_transceiver.sv
`default_nettype none
// Testbench for link_transceiver: directed + randomized traffic checked
// against a frame-level model (priority queueing, byte codes, frame rules).
module tb_link_transceiver;

    localparam int CPB = 16;
`ifdef LINK_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic send_connect = 1'b0, send_start = 1'b0, send_game_finish = 1'b0;
    logic rx_drv = 1'b1, loop_en = 1'b0;
    logic rx, tx, tx_busy, receive_connect, receive_start, receive_game_finish, rx_error;

    assign rx = loop_en ? tx : rx_drv;

    link_transceiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset),
        .send_connect(send_connect), .send_start(send_start),
        .send_game_finish(send_game_finish),
        .rx(rx), .tx(tx),
        .receive_connect(receive_connect), .receive_start(receive_start),
        .receive_game_finish(receive_game_finish),
        .tx_busy(tx_busy), .rx_error(rx_error)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;
    int n_conn = 0, n_start = 0, n_fin = 0, n_err = 0;
    logic [7:0] txq[$];

    always @(posedge clk) begin
        if (receive_connect === 1'b1)     n_conn  <= n_conn + 1;
        if (receive_start === 1'b1)       n_start <= n_start + 1;
        if (receive_game_finish === 1'b1) n_fin   <= n_fin + 1;
        if (rx_error === 1'b1)            n_err   <= n_err + 1;
    end

    // Line monitor: decodes every frame seen on tx into a byte queue
    initial begin : tx_monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB * (NBITS - 9)) @(negedge clk);
                txq.push_back(b);
            end
        end
    end

    initial begin : watchdog
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [NBITS-1:0] frame_of(input logic [7:0] b);
`ifdef LINK_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

    task automatic wait_idle(input string tag, input int budget);
        int c = 0;
        while ((tx_busy !== 1'b0 || tx !== 1'b1) && c < budget) begin
            tick(1);
            c++;
        end
        chk(tag, (c < budget), 1);
    endtask

    task automatic inject(input logic [7:0] b, input logic stop, input logic flip_par);
        rx_drv = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            tick(CPB);
        end
`ifdef LINK_PARITY_EN
        rx_drv = (^b) ^ flip_par;
        tick(CPB);
`endif
        rx_drv = stop;
        tick(CPB);
    endtask

    // Expected receiver outcome packed as {conn, start, fin, err}
    function automatic logic [31:0] rx_expect(input logic [7:0] b, input logic stop,
                                              input logic par_bad);
        if (!stop || par_bad) return 32'h0001;
        case (b)
            8'hA1:   return 32'h1000;
            8'hA2:   return 32'h0100;
            8'hA3:   return 32'h0010;
            default: return 32'h0001;
        endcase
    endfunction

    function automatic logic [31:0] deltas(input int c0, input int s0, input int f0, input int e0);
        return {16'h0, 4'(n_conn - c0), 4'(n_start - s0), 4'(n_fin - f0), 4'(n_err - e0)};
    endfunction

    initial begin : stimulus
        int c0, s0, f0, e0, len, cnt;
        logic [NBITS-1:0] fr;
        logic [2:0] m;
        logic [7:0] exp_q[$];
        logic [7:0] b;
        logic stp;

        // Reset state
        tick(3);
        chk("rst_tx", tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_recv", {receive_connect, receive_start, receive_game_finish}, 0);
        chk("rst_err", rx_error, 0);
        reset = 1'b0;
        tick(3);

        // Loopback: single START pulse, bit-exact waveform
        loop_en = 1'b1;
        txq.delete();
        c0 = n_conn; s0 = n_start; f0 = n_fin; e0 = n_err;
        send_start = 1'b1;
        tick(1);
        send_start = 1'b0;
        chk("t1_tx_before", tx, 1);
        chk("t1_busy_before", tx_busy, 0);
        tick(1);
        chk("t1_busy_first", tx_busy, 1);
        fr = frame_of(8'hA2);
        chk("t1_edge_tx", tx, 0);
        tick(CPB / 2);
        for (int i = 0; i < NBITS; i++) begin
            chk($sformatf("t1_bit%0d", i), tx, fr[i]);
            if (i < NBITS - 1) tick(CPB);
        end
        tick(CPB / 2 - 1);
        chk("t1_busy_last", tx_busy, 1);
        tick(1);
        chk("t1_busy_fall", tx_busy, 0);
        tick(CPB);
        chk("t1_rx_counts", deltas(c0, s0, f0, e0), 32'h0100);
        chk("t1_tx_byte", (txq.size() == 1) ? txq[0] : 8'h00, 8'hA2);

        // Level-held CONNECT gives one frame only
        txq.delete();
        c0 = n_conn; s0 = n_start; f0 = n_fin; e0 = n_err;
        send_connect = 1'b1;
        tick(1000);
        send_connect = 1'b0;
        wait_idle("t2_idle", 20 * NBITS * CPB);
        tick(CPB);
        chk("t2_frames", txq.size(), 1);
        chk("t2_byte", (txq.size() > 0) ? txq[0] : 8'h00, 8'hA1);
        chk("t2_rx_counts", deltas(c0, s0, f0, e0), 32'h1000);

        // Simultaneous edges: back-to-back in priority order
        txq.delete();
        c0 = n_conn; s0 = n_start; f0 = n_fin; e0 = n_err;
        {send_game_finish, send_start, send_connect} = 3'b111;
        tick(1);
        {send_game_finish, send_start, send_connect} = 3'b000;
        cnt = 0;
        while (tx_busy !== 1'b1 && cnt < 5) begin tick(1); cnt++; end
        len = 0;
        while (tx_busy === 1'b1 && len < 4 * NBITS * CPB) begin tick(1); len++; end
        chk("t3_busy_len_ok", (len >= 3 * NBITS * CPB) && (len <= 3 * NBITS * CPB + 2), 1);
        tick(CPB);
        chk("t3_frames", txq.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("t3_byte%0d", i), (txq.size() > i) ? txq[i] : 8'h00, 8'hA1 + 8'(i));
        chk("t3_rx_counts", deltas(c0, s0, f0, e0), 32'h1110);

        // Randomized send masks and pulse lengths
        for (int it = 0; it < 8; it++) begin
            txq.delete();
            exp_q.delete();
            c0 = n_conn; s0 = n_start; f0 = n_fin; e0 = n_err;
            m = 3'($urandom_range(1, 7));
            for (int k = 0; k < 3; k++) if (m[k]) exp_q.push_back(8'hA1 + 8'(k));
            {send_game_finish, send_start, send_connect} = m;
            tick($urandom_range(1, 3));
            {send_game_finish, send_start, send_connect} = 3'b000;
            tick(2);
            wait_idle($sformatf("t4_idle%0d", it), 4 * NBITS * CPB);
            tick(CPB);
            chk($sformatf("t4_frames%0d", it), txq.size(), exp_q.size());
            chk($sformatf("t4_order%0d", it), (txq == exp_q), 1);
            chk($sformatf("t4_rx%0d", it), deltas(c0, s0, f0, e0),
                {16'h0, 4'(m[0]), 4'(m[1]), 4'(m[2]), 4'h0});
        end

        // Receiver: invalid byte, stop-bit break, recovery
        loop_en = 1'b0;
        rx_drv = 1'b1;
        tick(2 * CPB);
        c0 = n_conn; s0 = n_start; f0 = n_fin; e0 = n_err;
        inject(8'h55, 1'b1, 1'b0);
        tick(CPB);
        chk("t5_bad_code", deltas(c0, s0, f0, e0), 32'h0001);
        c0 = n_conn; s0 = n_start; f0 = n_fin; e0 = n_err;
        inject(8'hA3, 1'b0, 1'b0);
        tick(4 * CPB);
        chk("t5_break_hold", deltas(c0, s0, f0, e0), 32'h0001);
        rx_drv = 1'b1;
        tick(2 * CPB);
        c0 = n_conn; s0 = n_start; f0 = n_fin; e0 = n_err;
        inject(8'hA1, 1'b1, 1'b0);
        tick(CPB);
        chk("t5_after_break", deltas(c0, s0, f0, e0), 32'h1000);

        // Randomized received frames
        for (int it = 0; it < 10; it++) begin
            b   = ($urandom_range(0, 1) == 0) ? 8'hA1 + 8'($urandom_range(0, 2)) : 8'($urandom);
            stp = ($urandom_range(0, 3) != 0);
            c0 = n_conn; s0 = n_start; f0 = n_fin; e0 = n_err;
            inject(b, stp, 1'b0);
            rx_drv = 1'b1;
            tick(2 * CPB);
            chk($sformatf("t5_rand%0d_b%0h_s%0d", it, b, stp), deltas(c0, s0, f0, e0),
                rx_expect(b, stp, 1'b0));
        end

        // Short glitch on idle line
        c0 = n_conn; s0 = n_start; f0 = n_fin; e0 = n_err;
        rx_drv = 1'b0;
        tick(5);
        rx_drv = 1'b1;
        tick(3 * CPB);
        chk("t6_glitch", deltas(c0, s0, f0, e0), 32'h0000);
        inject(8'hA2, 1'b1, 1'b0);
        rx_drv = 1'b1;
        tick(CPB);
        chk("t6_recover", deltas(c0, s0, f0, e0), 32'h0100);

`ifdef LINK_PARITY_EN
        c0 = n_conn; s0 = n_start; f0 = n_fin; e0 = n_err;
        inject(8'hA2, 1'b1, 1'b1);
        rx_drv = 1'b1;
        tick(CPB);
        chk("t7_par_bad", deltas(c0, s0, f0, e0), rx_expect(8'hA2, 1'b1, 1'b1));
        c0 = n_conn; s0 = n_start; f0 = n_fin; e0 = n_err;
        inject(8'hA2, 1'b1, 1'b0);
        rx_drv = 1'b1;
        tick(CPB);
        chk("t7_par_good", deltas(c0, s0, f0, e0), rx_expect(8'hA2, 1'b1, 1'b0));
`endif

        // Reset during bit 4 of a FINISH frame
        send_game_finish = 1'b1;
        tick(1);
        send_game_finish = 1'b0;
        tick(1);
        tick(4 * CPB + 3);
        chk("t8_midframe_busy", tx_busy, 1);
        reset = 1'b1;
        tick(1);
        chk("t8_rst_tx", tx, 1);
        chk("t8_rst_busy", tx_busy, 0);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12 * CPB; i++) begin
            if (tx !== 1'b1 || tx_busy !== 1'b0) cnt++;
            tick(1);
        end
        chk("t8_no_resend", cnt, 0);
        txq.delete();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
